// File: rtl/mem_stream_reader.sv
// Streams a contiguous address window of the shared sample/FFT memory out over valid/ready,
// using the start/done level handshake. Define STORE_MEM_CHECKSUM_EN to add a 16-bit checksum port.
module mem_stream_reader #(
  parameter int ADDR_W    = 11,
  parameter int DATA_W    = 10,
  parameter int BASE_ADDR = 0,
  parameter int NUM_WORDS = 2048
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              do_store,
  output logic              mem_stored,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
`ifdef STORE_MEM_CHECKSUM_EN
  ,
  output logic [15:0]       checksum
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  localparam int              CNT_W    = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

  state_t            state, state_next;
  logic [CNT_W-1:0]  rd_cnt;
  logic [CNT_W-1:0]  pop_cnt;
  logic [DATA_W-1:0] fifo_mem [2];
  logic              wr_ptr, rd_ptr;
  logic [1:0]        fifo_cnt;
  logic              data_pending;
  logic              fifo_valid, push, pop, credit, flush;

  assign fifo_valid = (fifo_cnt != 2'd0);
  assign pop        = fifo_valid && out_ready;
  assign push       = data_pending;
  assign flush      = (state_next == IDLE);
  // A new read is allowed only if, after this cycle's pop and landing word, it still fits.
  assign credit     = ({1'b0, fifo_cnt} + {2'b0, data_pending}) < (3'd2 + {2'b0, pop});

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (do_store) state_next = ISSUE;
      ISSUE: begin
        if (!do_store)                          state_next = IDLE;
        else if (credit && rd_cnt == LAST_IDX)  state_next = DRAIN;
      end
      DRAIN: begin
        if (!do_store)                          state_next = IDLE;
        else if (pop && pop_cnt == LAST_IDX)    state_next = DONE;
      end
      DONE:  if (!do_store) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    // NOTE: every output is defaulted first, so no branch can leave one unassigned and infer a latch.
    mem_rd_en  = 1'b0;
    mem_stored = 1'b0;
    mem_addr   = ADDR_W'(BASE_ADDR) + rd_cnt[ADDR_W-1:0];
    out_valid  = fifo_valid;
    out_data   = fifo_valid ? fifo_mem[rd_ptr] : '0;
    out_last   = fifo_valid && (pop_cnt == LAST_IDX);
    case (state)
      ISSUE:   mem_rd_en  = credit;
      DONE:    mem_stored = 1'b1;
      default: ;
    endcase
  end

  // Leaving for IDLE (abort or completion) flushes the buffer and drops any word still in flight.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_cnt       <= '0;
      pop_cnt      <= '0;
      fifo_cnt     <= 2'd0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      data_pending <= 1'b0;
    end else begin
      data_pending <= mem_rd_en;
      fifo_cnt     <= fifo_cnt + 2'(push) - 2'(pop);
      if (mem_rd_en) rd_cnt <= rd_cnt + 1'b1;
      if (push)      wr_ptr <= ~wr_ptr;
      if (pop) begin
        rd_ptr  <= ~rd_ptr;
        pop_cnt <= pop_cnt + 1'b1;
      end
    end
  end

  // NOTE: buffer storage is not reset; fifo_cnt decides what is visible and out_data is zero when empty.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= mem_data;
  end

`ifdef STORE_MEM_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst || state == IDLE) checksum <= 16'd0;
    else if (pop)             checksum <= checksum + 16'(out_data);
  end
`endif

endmodule
